// File: rtl/backprop_sequencer.sv
// Training-pass control FSM for backprop_stack: walks layers last to first,
// steps each row on diff_valid, then drains and counts weight-row updates.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        pass launch (IDLE only) / synchronous abort
//   num_layers          layer count latched on an accepted start
//   diff_valid          upstream diff data valid this cycle
//   is_update_weight    one weight-row update emitted by backprop_stack
//   current_input_layer layer index presented to backprop_stack
//   current_input_row   row index presented to backprop_stack
//   is_last_layer       current layer is layer n-1
//   start_new_layer     one-cycle pulse at each layer start
//   read_update_data    update drain request
//   active_train        row step valid
//   busy, done, error   pass status
//   update_count        update pulses counted this pass
module backprop_sequencer #(
    parameter int max_layer_size = 4,
    parameter int size           = 3,
    parameter int timeout_cycles = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  num_layers,
    input  logic        diff_valid,
    input  logic        is_update_weight,
    output logic [31:0] current_input_layer,
    output logic [31:0] current_input_row,
    output logic        is_last_layer,
    output logic        start_new_layer,
    output logic        read_update_data,
    output logic        active_train,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] update_count
);

    localparam int RW = (size > 1) ? $clog2(size) : 1;
    localparam int TW = $clog2(timeout_cycles + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(size - 1);
    localparam logic [TW-1:0] TO_LIM   = TW'(timeout_cycles);
    localparam logic [7:0]    MAX_L    = 8'(max_layer_size);
    localparam logic [15:0]   SIZE16   = 16'(size);

    typedef enum logic [2:0] {
        IDLE,
        START_LAYER,
        ROW,
        UPDATE,
        DONE
    } state_t;

    state_t        state;
    logic [7:0]    n_q;
    logic [7:0]    layer_q;
    logic [RW-1:0] row_q;
    logic [TW-1:0] to_cnt;
    logic          in_row;

    logic [15:0]   target;
    logic [15:0]   cnt_inc;
    logic [TW-1:0] to_inc;
    logic [7:0]    layer_dec;
    logic [RW-1:0] row_inc;
    logic          start_ok;

    assign target    = {8'd0, n_q} * SIZE16;
    assign cnt_inc   = update_count + 16'd1;
    assign to_inc    = to_cnt + TW'(1);
    assign layer_dec = layer_q - 8'd1;
    assign row_inc   = row_q + RW'(1);
    assign start_ok  = (num_layers != 8'd0) && (num_layers <= MAX_L);

    // The step strobe must coincide with the diff data it qualifies, so the
    // registered ROW flag is gated by the live diff_valid.
    assign active_train = in_row & diff_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            n_q                 <= '0;
            layer_q             <= '0;
            row_q               <= '0;
            to_cnt              <= '0;
            in_row              <= 1'b0;
            current_input_layer <= '0;
            current_input_row   <= '0;
            is_last_layer       <= 1'b0;
            start_new_layer     <= 1'b0;
            read_update_data    <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            update_count        <= '0;
        end else begin
            start_new_layer <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            if (abort && state != IDLE) begin
                state               <= IDLE;
                layer_q             <= '0;
                row_q               <= '0;
                to_cnt              <= '0;
                in_row              <= 1'b0;
                current_input_layer <= '0;
                current_input_row   <= '0;
                is_last_layer       <= 1'b0;
                read_update_data    <= 1'b0;
                busy                <= 1'b0;
                update_count        <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && start_ok) begin
                            state               <= START_LAYER;
                            n_q                 <= num_layers;
                            layer_q             <= num_layers - 8'd1;
                            row_q               <= '0;
                            to_cnt              <= '0;
                            update_count        <= '0;
                            start_new_layer     <= 1'b1;
                            busy                <= 1'b1;
                            current_input_layer <= {24'd0, num_layers - 8'd1};
                            current_input_row   <= '0;
                            is_last_layer       <= 1'b1;
                        end else if (start) begin
                            error <= 1'b1;
                        end
                    end
                    START_LAYER: begin
                        state  <= ROW;
                        in_row <= 1'b1;
                    end
                    ROW: begin
                        if (diff_valid) begin
                            if (row_q != ROW_LAST) begin
                                row_q             <= row_inc;
                                current_input_row <= {{(32-RW){1'b0}}, row_inc};
                            end else if (layer_q != 8'd0) begin
                                state               <= START_LAYER;
                                in_row              <= 1'b0;
                                layer_q             <= layer_dec;
                                row_q               <= '0;
                                start_new_layer     <= 1'b1;
                                current_input_layer <= {24'd0, layer_dec};
                                current_input_row   <= '0;
                                is_last_layer       <= (layer_dec == n_q - 8'd1);
                            end else begin
                                state            <= UPDATE;
                                in_row           <= 1'b0;
                                to_cnt           <= '0;
                                read_update_data <= 1'b1;
                                is_last_layer    <= 1'b0;
                            end
                        end
                    end
                    UPDATE: begin
                        // A pulse landing on the final count is counted
                        // before the exit; pulses after exit are ignored.
                        if (is_update_weight) begin
                            update_count <= cnt_inc;
                            to_cnt       <= '0;
                            if (cnt_inc == target) begin
                                state               <= DONE;
                                done                <= 1'b1;
                                read_update_data    <= 1'b0;
                                current_input_layer <= '0;
                                current_input_row   <= '0;
                            end
                        end else begin
                            to_cnt <= to_inc;
                            if (to_inc == TO_LIM) begin
                                state               <= DONE;
                                done                <= 1'b1;
                                error               <= 1'b1;
                                read_update_data    <= 1'b0;
                                current_input_layer <= '0;
                                current_input_row   <= '0;
                            end
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        layer_q <= '0;
                        row_q   <= '0;
                        to_cnt  <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_backprop_sequencer.sv
// Scoreboard bench for backprop_sequencer: expected layer/row/done events
// are queued at stimulus time and popped as the DUT emits them.
module tb_backprop_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_layers = 8'd0;
    logic        diff_valid = 1'b0;
    logic        is_update_weight = 1'b0;
    logic [31:0] current_input_layer;
    logic [31:0] current_input_row;
    logic        is_last_layer;
    logic        start_new_layer;
    logic        read_update_data;
    logic        active_train;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] update_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // kind: 0 layer start, 1 row step, 2 done
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] layer;
        logic [31:0] row;
        logic        flag;
        logic [15:0] cnt;
    } ev_t;

    ev_t sb[$];
    int  snl_t[$];
    int  done_t;

    backprop_sequencer #(
        .max_layer_size(4),
        .size(3),
        .timeout_cycles(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .num_layers(num_layers),
        .diff_valid(diff_valid),
        .is_update_weight(is_update_weight),
        .current_input_layer(current_input_layer),
        .current_input_row(current_input_row),
        .is_last_layer(is_last_layer),
        .start_new_layer(start_new_layer),
        .read_update_data(read_update_data),
        .active_train(active_train),
        .busy(busy),
        .done(done),
        .error(error),
        .update_count(update_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ev_t got;
        ev_t exp;
        cyc++;
        if (start_new_layer || active_train || done) begin
            if (start_new_layer) begin
                snl_t.push_back(cyc);
                got = '{2'd0, current_input_layer, current_input_row,
                        is_last_layer, 16'd0};
            end else if (active_train) begin
                got = '{2'd1, current_input_layer, current_input_row,
                        is_last_layer, 16'd0};
            end else begin
                done_t = cyc;
                got = '{2'd2, 32'd0, 32'd0, error, update_count};
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: kind=%0d layer=%0d row=%0d flag=%0d cnt=%0d, none expected",
                         got.kind, got.layer, got.row, got.flag, got.cnt);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL sb_event: got kind=%0d layer=%0d row=%0d flag=%0d cnt=%0d want kind=%0d layer=%0d row=%0d flag=%0d cnt=%0d",
                             got.kind, got.layer, got.row, got.flag, got.cnt,
                             exp.kind, exp.layer, exp.row, exp.flag, exp.cnt);
                end
            end
        end
    end

    task automatic push_layers(input int n);
        for (int l = n - 1; l >= 0; l--) begin
            sb.push_back('{2'd0, 32'(l), 32'd0, (l == n - 1), 16'd0});
            for (int r = 0; r < 3; r++)
                sb.push_back('{2'd1, 32'(l), 32'(r), (l == n - 1), 16'd0});
        end
    endtask

    task automatic push_done(input bit err, input int cnt);
        sb.push_back('{2'd2, 32'd0, 32'd0, err, 16'(cnt)});
    endtask

    task automatic start_pass(input int n);
        snl_t.delete();
        done_t = -1;
        @(posedge clk);
        #1 start = 1'b1;
        num_layers = 8'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_left: %0d events pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        total++;
        if ({busy, done, error, start_new_layer, read_update_data,
             active_train, is_last_layer} !== 7'd0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, done, error, start_new_layer, read_update_data,
                      active_train, is_last_layer});
        end
        total++;
        if ({current_input_layer, current_input_row, update_count} !== 80'd0) begin
            bad++;
            $display("FAIL reset_values: layer=%0d row=%0d cnt=%0d want 0",
                     current_input_layer, current_input_row, update_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        bit hit = 0;
        int upd = 0;
        int extra = 0;
        diff_valid = 1'b1;
        is_update_weight = 1'b1;
        push_layers(2);
        push_done(1'b0, 6);
        start_pass(2);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (read_update_data) upd++;
            if (done) hit = 1;
        end
        #1;
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL basic_done_timeout: no done within 100 cycles");
        end
        total++;
        if (snl_t.size() != 2 || snl_t[1] - snl_t[0] != 4) begin
            bad++;
            $display("FAIL basic_layer_gap: pulses=%0d gap=%0d want 2/4",
                     snl_t.size(), snl_t.size() > 1 ? snl_t[1] - snl_t[0] : -1);
        end
        total++;
        if (snl_t.size() == 0 || done_t - snl_t[0] != 14) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 14",
                     snl_t.size() > 0 ? done_t - snl_t[0] : -1);
        end
        total++;
        if (upd != 6) begin
            bad++;
            $display("FAIL basic_update_cycles: got %0d want 6", upd);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        total++;
        if (extra != 0 || update_count !== 16'd6 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_after: extra_done=%0d cnt=%0d busy=%b want 0/6/0",
                     extra, update_count, busy);
        end
        is_update_weight = 1'b0;
        check_sb_empty("basic");
    endtask

    task automatic test_stall;
        bit hit = 0;
        bit prev_low = 0;
        logic [31:0] prev_row = '0;
        diff_valid = 1'b1;
        is_update_weight = 1'b1;
        push_layers(2);
        push_done(1'b0, 6);
        start_pass(2);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1;
            if (busy && !start_new_layer && !read_update_data && !done) begin
                total++;
                if (active_train !== diff_valid) begin
                    bad++;
                    $display("FAIL stall_active: got %b want %b",
                             active_train, diff_valid);
                end
                if (prev_low) begin
                    total++;
                    if (current_input_row !== prev_row) begin
                        bad++;
                        $display("FAIL stall_row_hold: got %0d want %0d",
                                 current_input_row, prev_row);
                    end
                end
                prev_low = !diff_valid;
                prev_row = current_input_row;
            end else begin
                prev_low = 0;
            end
            @(posedge clk);
            #1 diff_valid = ~diff_valid;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL stall_done_timeout: no done within 100 cycles");
        end
        is_update_weight = 1'b0;
        diff_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_sb_empty("stall");
    endtask

    task automatic test_reject;
        int nl[2] = '{0, 5};
        foreach (nl[k]) begin
            @(posedge clk);
            #1 start = 1'b1;
            num_layers = 8'(nl[k]);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            total++;
            if (error !== 1'b1 || busy !== 1'b0 || start_new_layer !== 1'b0) begin
                bad++;
                $display("FAIL reject_%0d: error=%b busy=%b snl=%b want 1/0/0",
                         nl[k], error, busy, start_new_layer);
            end
            @(negedge clk);
            total++;
            if (error !== 1'b0 || busy !== 1'b0 || read_update_data !== 1'b0) begin
                bad++;
                $display("FAIL reject_%0d_after: error=%b busy=%b rud=%b want 0/0/0",
                         nl[k], error, busy, read_update_data);
            end
        end
        check_sb_empty("reject");
    endtask

    task automatic test_timeout;
        bit hit = 0;
        diff_valid = 1'b1;
        is_update_weight = 1'b0;
        push_layers(1);
        push_done(1'b1, 0);
        start_pass(1);
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1;
        end
        #1;
        total++;
        if (!hit || snl_t.size() == 0 || done_t - snl_t[0] != 68) begin
            bad++;
            $display("FAIL timeout_latency: hit=%b got %0d want 68", hit,
                     snl_t.size() > 0 ? done_t - snl_t[0] : -1);
        end
        repeat (2) @(negedge clk);
        check_sb_empty("timeout");
    endtask

    task automatic test_abort;
        bit hit = 0;
        diff_valid = 1'b1;
        is_update_weight = 1'b1;
        push_layers(3);
        sb = sb[0:5];
        start_pass(3);
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (start_new_layer && current_input_layer == 32'd1) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL abort_reach_layer1: layer 1 never started");
        end
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, error, start_new_layer, read_update_data,
             active_train, is_last_layer} !== 7'd0 ||
            current_input_layer !== 32'd0 || current_input_row !== 32'd0 ||
            update_count !== 16'd0) begin
            bad++;
            $display("FAIL abort_outputs: flags=%b layer=%0d row=%0d cnt=%0d want all 0",
                     {busy, done, error, start_new_layer, read_update_data,
                      active_train, is_last_layer},
                     current_input_layer, current_input_row, update_count);
        end
        repeat (5) @(negedge clk);
        check_sb_empty("abort");
        hit = 0;
        push_layers(3);
        push_done(1'b0, 9);
        start_pass(3);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL abort_restart: no done within 100 cycles");
        end
        is_update_weight = 1'b0;
        repeat (2) @(negedge clk);
        check_sb_empty("abort_restart");
    endtask

    task automatic test_async_reset;
        bit hit = 0;
        diff_valid = 1'b1;
        is_update_weight = 1'b0;
        push_layers(2);
        start_pass(2);
        @(negedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        num_layers = 8'd4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (read_update_data) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL areset_reach_update: UPDATE never entered");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, error, start_new_layer, read_update_data,
             active_train, is_last_layer} !== 7'd0 ||
            update_count !== 16'd0 || current_input_layer !== 32'd0 ||
            current_input_row !== 32'd0) begin
            bad++;
            $display("FAIL areset_immediate: flags=%b cnt=%0d layer=%0d row=%0d want all 0",
                     {busy, done, error, start_new_layer, read_update_data,
                      active_train, is_last_layer},
                     update_count, current_input_layer, current_input_row);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || read_update_data !== 1'b0) begin
            bad++;
            $display("FAIL areset_idle: busy=%b rud=%b want 0/0",
                     busy, read_update_data);
        end
        check_sb_empty("areset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reject();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
